// File: rtl/imc_mig_pkg.sv
// Shared definitions for the MIG memory responder: geometry, FSM encoding
// and the bitwise majority-of-three function.
package imc_mig_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_WB   = 3'd4
  } mig_state_t;

  // A result bit is 1 when at least two of the three operand bits are 1.
  function automatic logic [DATA_W-1:0] maj3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/imc_maj3_voter.sv
// Combinational bitwise 3-input majority over one data word.
module imc_maj3_voter
  import imc_mig_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  output logic [DATA_W-1:0] o_maj
);

  assign o_maj = maj3(i_a, i_b, i_c);

endmodule

// File: rtl/imc_mig_mem_responder.sv
// Memory-side responder for the MIG control interface: a 32x32 flop array
// with single-cycle read/write and a four-cycle majority-of-three command.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepts commands (execute_MIG > WE > OE) when CS=1
// RD0    | op0 <= row[base]
// RD1    | op1 <= row[base+1]
// RD2    | op2 <= row[base+2]
// WB     | row[base+3] <= maj(op0, op1, op2); mig_done high
module imc_mig_mem_responder
  import imc_mig_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              CS,
  input  logic              WE,
  input  logic              OE,
  input  logic              execute_MIG,
  input  logic [ADDR_W-1:0] address_MIG,
  inout  wire  [DATA_W-1:0] data_bus_MIG_mem,
  output logic              busy,
  output logic              mig_done
);

  mig_state_t        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_op0;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_mig_done;
  logic [DATA_W-1:0] r_rows [DEPTH];

  logic              w_idle;
  logic              w_cmd_mig;
  logic              w_cmd_wr;
  logic              w_cmd_rd;
  logic              w_wb_wr;
  logic [ADDR_W-1:0] w_op_addr;
  logic [DATA_W-1:0] w_maj;

  assign w_idle    = (r_state == S_IDLE);
  assign w_cmd_mig = w_idle & CS & execute_MIG;
  assign w_cmd_wr  = w_idle & CS & ~execute_MIG & WE;
  assign w_cmd_rd  = w_idle & CS & ~execute_MIG & ~WE & OE;
  assign w_wb_wr   = (r_state == S_WB);

  // Row touched by the current MIG phase; the add wraps at ADDR_W bits.
  always_comb begin
    w_op_addr = r_base;
    case (r_state)
      S_RD1:   w_op_addr = r_base + ADDR_W'(1);
      S_RD2:   w_op_addr = r_base + ADDR_W'(2);
      S_WB:    w_op_addr = r_base + ADDR_W'(3);
      default: w_op_addr = r_base;
    endcase
  end

  imc_maj3_voter u_voter (
    .i_a   (r_op0),
    .i_b   (r_op1),
    .i_c   (r_op2),
    .o_maj (w_maj)
  );

  // Command FSM, operand capture, read data and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_op0      <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_mig_done <= 1'b0;
    end else begin
      r_rd_valid <= w_cmd_rd;
      if (w_cmd_rd) r_rd_data <= r_rows[address_MIG];
      case (r_state)
        S_IDLE: begin
          if (w_cmd_mig) begin
            r_base  <= address_MIG;
            r_state <= S_RD0;
            r_busy  <= 1'b1;
          end
        end
        S_RD0: begin
          r_op0   <= r_rows[w_op_addr];
          r_state <= S_RD1;
        end
        S_RD1: begin
          r_op1   <= r_rows[w_op_addr];
          r_state <= S_RD2;
        end
        S_RD2: begin
          r_op2      <= r_rows[w_op_addr];
          r_state    <= S_WB;
          r_mig_done <= 1'b1;
        end
        S_WB: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_mig_done <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_mig_done <= 1'b0;
        end
      endcase
    end
  end

  // Row array: host writes only in IDLE, MIG result only in WB, never both.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_rows[i] <= '0;
    end else if (w_cmd_wr) begin
      r_rows[address_MIG] <= data_bus_MIG_mem;
    end else if (w_wb_wr) begin
      r_rows[w_op_addr] <= w_maj;
    end
  end

  // OE gates the drive combinationally so the master can turn the bus around
  // without waiting for rd_valid to clear.
  assign data_bus_MIG_mem = (r_rd_valid & OE) ? r_rd_data : {DATA_W{1'bz}};
  assign busy             = r_busy;
  assign mig_done         = r_mig_done;

endmodule
